// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and default sizes.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;
    localparam int unsigned DEF_GAP   = 1;

endpackage

// File: rtl/seq_tx_shifter.sv
// WIDTH-bit load/shift register presenting its MSB, plus a down-counter flagging the last bit of a copy.
module seq_tx_shifter
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb,
    output logic             last
);

    localparam int unsigned BIT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;

    // Load wins over shift so a copy boundary can reload in the same cycle it sends its last bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= din;
            bit_cnt <= BIT_W'(WIDTH - 1);
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - BIT_W'(1);
            end
        end
    end

    assign msb  = shreg[WIDTH-1];
    assign last = (bit_cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a loaded WIDTH-bit pattern MSB-first on w, load_reps+1 times,
// with GAP idle cycles between copies and a one-cycle done pulse after the final bit.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_reps,
    input  logic             enable,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [CNT_W-1:0] reps_left;
    logic [GAP_W-1:0] gap_cnt;
    logic             done_pend;

    logic             accept;
    logic             step_shift;
    logic             copy_end;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             sh_msb;
    logic             sh_last;

    assign load_ready = (state == ST_IDLE);
    assign accept     = load_valid && load_ready;
    assign step_shift = (state == ST_SHIFT) && enable;
    assign copy_end   = step_shift && sh_last;

    // Shifter control: fresh load from the port, or reload from the hold reg at a copy boundary.
    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = hold;
        if (accept) begin
            sh_load = 1'b1;
            sh_din  = load_data;
        end else if (copy_end && (reps_left != '0)) begin
            sh_load = 1'b1;
        end else if (step_shift) begin
            sh_shift = 1'b1;
        end
    end

    seq_tx_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb),
        .last  (sh_last)
    );

    // FSM, repeat/gap counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hold      <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            done_pend <= 1'b0;
            w         <= 1'b0;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= done_pend;
            done_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    if (accept) begin
                        hold      <= load_data;
                        reps_left <= load_reps;
                        state     <= ST_SHIFT;
                        busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (enable) begin
                        w       <= sh_msb;
                        w_valid <= 1'b1;
                        if (sh_last) begin
                            if (reps_left != '0) begin
                                reps_left <= reps_left - CNT_W'(1);
                                if (GAP > 0) begin
                                    state   <= ST_GAP;
                                    gap_cnt <= GAP_W'(GAP);
                                end
                            end else begin
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                                done_pend <= 1'b1;
                            end
                        end
                    end else begin
                        w_valid <= 1'b0;
                    end
                end
                ST_GAP: begin
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    if (enable) begin
                        if (gap_cnt <= GAP_W'(1)) begin
                            gap_cnt <= '0;
                            state   <= ST_SHIFT;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed scenarios plus random traffic against a queue-based model.
module tb_seq_pattern_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP   = 1;
    localparam int          TOK_GAP = 2;

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [CNT_W-1:0] load_reps;
    logic             enable;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;

    seq_pattern_tx #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .GAP   (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_reps  (load_reps),
        .enable     (enable),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a queue of pending line events (bit values 0/1, or a gap token).
    int   q[$];
    logic m_w, m_wv, m_done, m_pend, m_busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] got;
    int          nbits, ndone, done_cyc, first_bit_cyc;
    logic        first_bit_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] d;
        int               tok;
        m_done = m_pend;
        m_pend = 1'b0;
        if (q.size() == 0) begin
            m_w  = 1'b0;
            m_wv = 1'b0;
            if (load_valid) begin
                d = load_data;
                for (int c = 0; c <= int'(load_reps); c++) begin
                    if (c > 0) for (int g = 0; g < int'(GAP); g++) q.push_back(TOK_GAP);
                    for (int b = WIDTH - 1; b >= 0; b--) q.push_back(int'(d[b]));
                end
            end
        end else if (enable) begin
            tok = q.pop_front();
            if (tok == TOK_GAP) begin
                m_w  = 1'b0;
                m_wv = 1'b0;
            end else begin
                m_w  = tok[0];
                m_wv = 1'b1;
                if (q.size() == 0) m_pend = 1'b1;
            end
        end else begin
            m_wv = 1'b0;
            if (q[0] == TOK_GAP) m_w = 1'b0;
        end
        m_busy = (q.size() != 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("w", 32'(w), 32'(m_w));
        chk("w_valid", 32'(w_valid), 32'(m_wv));
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("load_ready", 32'(load_ready), 32'(q.size() == 0));
        if (w_valid) begin
            got = {got[30:0], w};
            nbits++;
            if (ndone > 0 && first_bit_cyc < 0) begin
                first_bit_cyc = cyc;
                first_bit_val = w;
            end
        end
        if (done) begin
            if (ndone == 0) done_cyc = cyc;
            ndone++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clr();
        got           = '0;
        nbits         = 0;
        ndone         = 0;
        done_cyc      = -1;
        first_bit_cyc = -1;
        first_bit_val = 1'bx;
    endtask

    task automatic load(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] r);
        load_data  = d;
        load_reps  = r;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    task automatic wait_bits(input int n);
        int budget = 0;
        while (nbits < n && budget < 60) begin
            step();
            budget++;
        end
        chk("wait_bits_timeout", 32'(nbits >= n), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        q.delete();
        m_w = 1'b0; m_wv = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_busy = 1'b0;
        chk("rst_w", 32'(w), 32'd0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_reps  = '0;
        enable     = 1'b1;
        clr();
        do_reset();
        run(2);

        // Single copy of 8'hB2.
        clr();
        load(8'hB2, 4'd0);
        run(10);
        chk("single_bits", 32'(nbits), 32'd8);
        chk("single_data", {24'd0, got[7:0]}, 32'h0000_00B2);
        chk("single_done", 32'(ndone), 32'd1);

        // Three copies with one gap cycle between them.
        clr();
        load(8'hB2, 4'd2);
        run(30);
        chk("rep_bits", 32'(nbits), 32'd24);
        chk("rep_data", {8'd0, got[23:0]}, 32'h00B2_B2B2);
        chk("rep_done", 32'(ndone), 32'd1);

        // Stall for three cycles after bit 3.
        clr();
        load(8'hB2, 4'd0);
        wait_bits(3);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(8);
        chk("stall_bits", 32'(nbits), 32'd8);
        chk("stall_data", {24'd0, got[7:0]}, 32'h0000_00B2);
        chk("stall_done", 32'(ndone), 32'd1);

        // Load offered while busy is ignored.
        clr();
        load(8'hB2, 4'd0);
        run(3);
        load(8'hFF, 4'd0);
        run(10);
        chk("busyload_bits", 32'(nbits), 32'd8);
        chk("busyload_data", {24'd0, got[7:0]}, 32'h0000_00B2);

        // Reset mid-transfer aborts without done; a new load then runs cleanly.
        clr();
        load(8'hB2, 4'd0);
        wait_bits(4);
        do_reset();
        clr();
        run(4);
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_no_bits", 32'(nbits), 32'd0);
        clr();
        load(8'h5A, 4'd1);
        run(22);
        chk("post_rst_data", {16'd0, got[15:0]}, 32'h0000_5A5A);
        chk("post_rst_done", 32'(ndone), 32'd1);

        // Back-to-back: next load accepted on the edge that raises done.
        clr();
        load(8'hB2, 4'd0);
        wait_bits(8);
        load(8'h0F, 4'd0);
        run(10);
        chk("b2b_data", {16'd0, got[15:0]}, 32'h0000_B20F);
        chk("b2b_first_bit", 32'(first_bit_val), 32'd0);
        chk("b2b_no_bubble", 32'(first_bit_cyc - done_cyc), 32'd1);
        chk("b2b_done", 32'(ndone), 32'd2);

        // Random traffic: random patterns, repeats, enable stalls and stray loads.
        for (int t = 0; t < 20; t++) begin
            clr();
            load(WIDTH'($urandom), CNT_W'($urandom_range(0, 3)));
            for (int i = 0; i < 50; i++) begin
                enable     = ($urandom_range(0, 3) != 0);
                load_valid = ($urandom_range(0, 9) == 0);
                load_data  = WIDTH'($urandom);
                load_reps  = CNT_W'($urandom_range(0, 2));
                step();
            end
            enable     = 1'b1;
            load_valid = 1'b0;
            run(40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
